// File: rtl/multiplier_operand_loader.sv
// Operand feeder for the sequential multiplier: assembles multiplier/multiplicand
// from a BUS_W-bit valid/ready word stream, pulses start, then waits for productDone.
module multiplier_operand_loader #(
  parameter int WIDTH = 2048,
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  output logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] multiplicand,
  output logic             start,
  input  logic             productDone,
  output logic             busy
);

  localparam int WORDS = WIDTH / BUS_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SH_W  = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
  localparam logic [WIDTH-1:0] WORD_MASK = {{(WIDTH-BUS_W){1'b0}}, {BUS_W{1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MR,
    LOAD_MD,
    START,
    WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = in_valid && in_ready;

  // Replace word idx of r with w; every other bit is preserved.
  function automatic logic [WIDTH-1:0] put_word(input logic [WIDTH-1:0] r,
                                                input logic [CNT_W-1:0] idx,
                                                input logic [BUS_W-1:0] w);
    logic [SH_W-1:0] sh;
    sh = SH_W'(idx) * SH_W'(BUS_W);
    return (r & ~(WORD_MASK << sh)) | (WIDTH'(w) << sh);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      multiplier   <= '0;
      multiplicand <= '0;
      start        <= 1'b0;
      busy         <= 1'b0;
      in_ready     <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            multiplier <= put_word(multiplier, '0, in_data);
            cnt        <= CNT_W'(1);
            busy       <= 1'b1;
            state      <= LOAD_MR;
          end
        end
        LOAD_MR: begin
          if (accept) begin
            multiplier <= put_word(multiplier, cnt, in_data);
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= LOAD_MD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        LOAD_MD: begin
          if (accept) begin
            multiplicand <= put_word(multiplicand, cnt, in_data);
            if (cnt == LAST) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              start    <= 1'b1;
              state    <= START;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          // productDone is only meaningful here; a stale level elsewhere is ignored.
          if (productDone) begin
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
